// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: excitation codes and the inverse
// characteristic that maps a (current, desired) bit pair onto {j,k}.
package jk_pkg;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Inverse JK characteristic. Don't-cares resolve to 0, so toggle is never produced.
    function automatic logic [1:0] jk_excite(input logic q, input logic q_next);
        logic [1:0] jk;
        case ({q, q_next})
            2'b01:   jk = JK_SET;
            2'b10:   jk = JK_RESET;
            default: jk = JK_HOLD;
        endcase
        return jk;
    endfunction

endpackage

// File: rtl/jk_stage.sv
// Single JK flip-flop stage: updates on the falling clock edge and is
// cleared asynchronously by an active-low clear.
module jk_stage (
    input  logic clk,
    input  logic clr_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // JK characteristic equation.
    always_comb begin
        q_d = (j & ~q_q) | (~k & q_q);
    end

    // Falling-edge state bit with asynchronous clear.
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Up/down modulo-MOD counter built from JK stages. The desired next state is
// computed first, then turned into per-bit J/K excitation for the stages.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             load_err
);

    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
        $fatal(1, "jk_mod_counter: WIDTH must be in 1..16");
    end else if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
        $fatal(1, "jk_mod_counter: MOD must be in 2..2**WIDTH");
    end

    // The modulus may equal 2**WIDTH, so the range compare needs one extra bit.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

    logic [WIDTH-1:0] nxt_s;
    logic             wrap_s;
    logic             bad_load_s;
    logic             tc_q;
    logic             tc_d;
    logic             load_err_q;
    logic             load_err_d;

    // Target next state: load beats count beats hold; out-of-range loads saturate.
    always_comb begin
        nxt_s      = q;
        wrap_s     = 1'b0;
        bad_load_s = 1'b0;
        if (load) begin
            if ({1'b0, load_val} < MOD_W) begin
                nxt_s = load_val;
            end else begin
                nxt_s      = MAX_V;
                bad_load_s = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (q == MAX_V) begin
                    nxt_s  = ZERO_V;
                    wrap_s = 1'b1;
                end else begin
                    nxt_s = q + ONE_V;
                end
            end else begin
                if (q == ZERO_V) begin
                    nxt_s  = MAX_V;
                    wrap_s = 1'b1;
                end else begin
                    nxt_s = q - ONE_V;
                end
            end
        end else begin
            nxt_s = q;
        end
    end

    // Per-bit J/K excitation that steers each stage onto the target state.
    always_comb begin
        j_vec = {WIDTH{1'b0}};
        k_vec = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            {j_vec[i], k_vec[i]} = jk_excite(q[i], nxt_s[i]);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_stage
        jk_stage u_stage (
            .clk   (clk),
            .clr_n (clr_n),
            .j     (j_vec[g]),
            .k     (k_vec[g]),
            .q     (q[g])
        );
    end

    // Next values for the wrap pulse and the sticky load-error flag.
    always_comb begin
        tc_d       = wrap_s;
        load_err_d = load_err_q | bad_load_s;
    end

    // Status flags share the stages' falling-edge timing and clear.
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- WIDTH-bit up/down modulo-MOD counter. Every state bit is a JK flip-flop stage.
- Each stage is driven by JK excitation logic derived from the desired next state, i.e. the inverse of the JK characteristic: given q and q_next, produce j and k.
- Serves as the standard way the codebase builds counters from JK stages. Exposes the excitation vectors so benches can cross-check them against the jkff primitive's behaviour.

Parameters:
- WIDTH, 4, counter width in bits; 1..16.
- MOD, 10, count modulus; sequence is 0..MOD-1; legal range 2 <= MOD <= 2**WIDTH.

Ports:
- clk  in  1  clock; all state updates on the falling edge (1->0), matching the jkff primitive.
- clr_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load request.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  current count.
- j_vec  out  WIDTH  J excitation per bit for the coming edge (combinational).
- k_vec  out  WIDTH  K excitation per bit for the coming edge (combinational).
- tc  out  1  registered terminal-count pulse.
- load_err  out  1  sticky flag: an out-of-range load occurred.

Behaviour:
- Reset:
  - clr_n=0 forces q=0, tc=0, load_err=0 immediately, with no clock needed.
  - Deassertion is sampled at falling edges only.
  - Reset asserted mid-count aborts the operation; no partial update.
- Priority per falling edge: load > en > hold.
- Target next state nxt:
  - load=1: nxt = load_val if load_val < MOD, else MOD-1. An out-of-range load also sets load_err=1 on that edge.
  - en=1, up=1: nxt = q+1, or 0 when q == MOD-1.
  - en=1, up=0: nxt = q-1, or MOD-1 when q == 0.
  - Otherwise: nxt = q.
- Excitation (don't-cares resolved to 0):
  - j_vec = ~q & nxt
  - k_vec = q & ~nxt
  - The toggle code j=k=1 is never generated.
  - When holding, j_vec = k_vec = 0.
- Stage update per bit, on the falling edge: q_i <= (j_i & ~q_i) | (~k_i & q_i). The result must always equal nxt; the bench asserts this every edge.
- tc:
  - Set to 1 on an edge where a counting wrap occurs: up and MOD-1 -> 0, or down and 0 -> MOD-1.
  - Set to 0 on all other edges, so it is high for exactly one clk period.
  - A load onto MOD-1 or 0 does not raise tc.
- load_err: cleared only by clr_n.
- load and en asserted together: the load wins; no count and no tc on that edge.
- Width rule: arithmetic is done in WIDTH+1 bits internally. No overflow is possible since MOD <= 2**WIDTH.
- Latency: q reflects a request on the first falling edge at which it is sampled. j_vec/k_vec respond combinationally to inputs and q.
- Elaboration check: a parameter outside the legal ranges is a fatal error.

Decomposition:
- Package jk_pkg:
  - Excitation constants: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
  - Function jk_excite(q, q_next) returning {j,k}.
- Sub-module jk_stage: one bit. Inputs clk, clr_n, j, k; output q. Falling-edge, async active-low clear.
- Top level: WIDTH instances of jk_stage plus next-state/tc/load_err logic.

Test Plan (WIDTH=4, MOD=10):
1. Reset: clr_n=0 between edges -> q=0, tc=0, load_err=0 with no clock edge; release and hold en=0 for 3 edges -> q stays 0, j_vec=k_vec=0.
2. Up count: en=1, up=1 for 12 falling edges from 0 -> q = 1..9,0,1,2. tc=1 only for the period after the 9->0 edge. At q=7 before the edge, j_vec=4'b1000 and k_vec=4'b0111.
3. Down count: load 0, then en=1, up=0 -> q = 9,8,7. tc pulses after the 0->9 edge; at q=0, j_vec=4'b1001 and k_vec=0.
4. Load priority: load=1, load_val=5, en=1, up=1 at q=9 -> q=5, tc=0. Next edge with load=0 -> q=6.
5. Bad load: load_val=12 -> q=9, load_err=1. load_err stays 1 across further counting until clr_n=0 clears it.
6. Reset mid-count: pulse clr_n low while q=6 and en=1 -> q=0 immediately; counting resumes 1,2,... after release. Every edge the bench checks q_new == jk characteristic(q_old, j_vec, k_vec) and that j&k is never set.
